branch_jump_unit: RTL and testbench
===================================

// Module: branch_jump_unit
// PURPOSE
//  Multi-lane branch/jump target unit for the superscalar front-end. One pipeline stage.
//  Per issue lane: decodes B/J/JALR opcodes, computes targets, flags misalignment and
//  supplies a taken prediction from a shared direct-mapped BTB with 2-bit counters.
//  The BTB is trained by the execute-stage resolve port. Sits between decode and fetch-redirect.
// PARAMETERS
//  XLEN       32  data/address width
//  LANES      2   issue lanes evaluated per cycle
//  BTB_DEPTH  16  BTB entries, power of 2, >=2; IDX_W=$clog2(BTB_DEPTH), TAG_W=XLEN-2-IDX_W
// PORTS
//  clk          in   1            clock, rising edge
//  rst_n        in   1            asynchronous reset, active low
//  stall_i      in   1            hold stage register contents
//  flush_i      in   1            squash all lanes in the stage register
//  in_valid_i   in   LANES        lane carries an instruction
//  pc_i         in   LANES*XLEN   lane PC (lane k at [k*XLEN +: XLEN])
//  opcode_i     in   LANES*7      lane opcode
//  imm_i        in   LANES*XLEN   sign-extended immediate
//  rs1_i        in   LANES*XLEN   rs1 value (JALR only)
//  out_valid_o  out  LANES        lane holds a control-flow instruction
//  target_o     out  LANES*XLEN   computed target address
//  branch_o     out  LANES        lane is B_TYPE
//  jump_o       out  LANES        lane is J_TYPE or JALR_TYPE
//  misalign_o   out  LANES        target[1] set (IALIGN=32 fault)
//  pred_taken_o out  LANES        predicted taken
//  upd_valid_i  in   1            resolve/train strobe
//  upd_pc_i     in   XLEN         PC of resolved branch
//  upd_taken_i  in   1            actual direction
//  upd_target_i in   XLEN         actual target
// BEHAVIOUR
//  - Reset: all outputs 0, every BTB valid bit cleared; asserting rst_n low mid-operation
//    zeroes outputs immediately, regardless of stall/flush.
//  - Latency 1: lane inputs sampled at edge N appear on outputs after edge N.
//  - Edge priority: flush_i > stall_i > load. flush clears out_valid_o (other fields don't care);
//    stall holds every output bit; otherwise load.
//  - Per lane, on load: ctrl = in_valid & opcode in {B_TYPE,J_TYPE,JALR_TYPE}.
//    B/J: target = pc+imm; JALR: target = (rs1+imm) & ~1. Sum mod 2^XLEN, carry dropped.
//    Non-ctrl or invalid lane: out_valid/branch/jump/misalign/pred_taken = 0, target = 0.
//    misalign = target[1] (ctrl lanes only).
//  - Prediction: J/JALR -> pred_taken=1. B -> hit & ctr[1]. Miss -> 0.
//    hit = valid[idx] & tag[idx]==pc[XLEN-1:IDX_W+2]; idx = pc[IDX_W+1:2].
//  - BTB lookup is combinational on pc_i, registered with the stage (LANES read ports).
//  - Training (one write port), at the edge where upd_valid_i=1, independent of stall/flush:
//    hit & taken: ctr=sat_inc(ctr), target=upd_target. hit & !taken: ctr=sat_dec(ctr).
//    miss & taken: allocate/replace, valid=1, ctr=2'b10, tag, target. miss & !taken: no write.
//    Counter saturates at 2'b11 and 2'b00, never wraps.
//  - Same-cycle lookup and update to the same index: the lookup sees pre-update contents.
// STRUCTURE
//  - Package variables.sv: B_TYPE, J_TYPE, and new JALR_TYPE=7'b1100111; typedef ctr2_t (2-bit);
//    typedef btb_entry_t {valid, tag, ctr2_t ctr, target}.
//  - Sub-module bju_btb: storage, LANES read ports, train port.
//  - Top: per-lane generate loop of the adder/decode plus the stage register.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> all outputs 0 at once; after release a B lookup at 0x100 -> pred_taken=0.
//  2 Targets: lane0 B pc=0x1000 imm=-8 -> 0xFF8; lane1 JALR rs1=0x2003 imm=4 -> 0x2006,
//    misalign=1, jump=1; both one cycle later.
//  3 Train: 3x upd taken pc=0x40 tgt=0x80, then B lookup 0x40 -> pred=1; 3x not-taken ->
//    pred=0; a 4th not-taken keeps ctr=00.
//  4 Alias (DEPTH=16): train pc=0x40, then lookup 0x80 (same idx, other tag) -> miss, pred=0;
//    taken update at 0x80 replaces the entry.
//  5 Stall/flush: stall 3 cycles -> outputs frozen; flush+stall together -> out_valid=0;
//    update during stall still trains.
//  6 Wrap: pc=0xFFFF_FFFC imm=8 -> target 0x0000_0004; non-ctrl opcode -> out_valid=0.

Source files
------------

// File: rtl/branch_jump_unit_pkg.sv
// Shared opcodes, BTB entry layout and saturating-counter helpers for the branch/jump unit.
package branch_jump_unit_pkg;

  localparam int XLEN_P = 32;

  localparam logic [6:0] B_TYPE    = 7'b1100011;
  localparam logic [6:0] J_TYPE    = 7'b1101111;
  localparam logic [6:0] JALR_TYPE = 7'b1100111;

  typedef logic [1:0] ctr2_t;

  // tag holds pc >> (IDX_W+2) zero-extended, so one layout serves any BTB depth
  typedef struct packed {
    logic              valid;
    logic [XLEN_P-1:0] tag;
    ctr2_t             ctr;
    logic [XLEN_P-1:0] target;
  } btb_entry_t;

  function automatic ctr2_t sat_inc(ctr2_t c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic ctr2_t sat_dec(ctr2_t c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/bju_btb.sv
// Direct-mapped BTB with 2-bit counters: LANES combinational read ports, one train port.
module bju_btb
  import branch_jump_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int LANES     = 2,
  parameter int BTB_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANES*XLEN-1:0] rd_pc,
  output logic [LANES-1:0]      rd_taken,
  input  logic                  upd_valid,
  input  logic [XLEN-1:0]       upd_pc,
  input  logic                  upd_taken,
  input  logic [XLEN-1:0]       upd_target
);

  localparam int IDX_W = $clog2(BTB_DEPTH);

  btb_entry_t mem [BTB_DEPTH];

  function automatic logic [XLEN_P-1:0] tag_of(logic [XLEN-1:0] pc);
    return XLEN_P'(pc >> (IDX_W + 2));
  endfunction

  logic [LANES-1:0] unused_rd_target;

  for (genvar k = 0; k < LANES; k++) begin : g_rd
    logic [XLEN-1:0]  pc;
    logic [IDX_W-1:0] idx;
    btb_entry_t       e;
    assign pc  = rd_pc[k*XLEN +: XLEN];
    assign idx = pc[IDX_W+1:2];
    assign e   = mem[idx];
    assign rd_taken[k]         = e.valid && (e.tag == tag_of(pc)) && e.ctr[1];
    assign unused_rd_target[k] = ^e.target;
  end

  logic [IDX_W-1:0] u_idx;
  btb_entry_t       u_e;
  logic             u_hit;
  logic             unused_upd_target;

  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_e   = mem[u_idx];
  assign u_hit = u_e.valid && (u_e.tag == tag_of(upd_pc));
  assign unused_upd_target = ^u_e.target;

  // Reads above see the array before this edge's write, so same-index lookups get old contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) mem[i] <= '0;
    end else if (upd_valid) begin
      if (u_hit) begin
        if (upd_taken) begin
          mem[u_idx].ctr    <= sat_inc(u_e.ctr);
          mem[u_idx].target <= upd_target;
        end else begin
          mem[u_idx].ctr <= sat_dec(u_e.ctr);
        end
      end else if (upd_taken) begin
        mem[u_idx] <= '{valid: 1'b1, tag: tag_of(upd_pc), ctr: 2'b10, target: upd_target};
      end
    end
  end

endmodule

// File: rtl/branch_jump_unit.sv
// Per-lane branch/jump decode and target adders with BTB prediction, one registered stage.
module branch_jump_unit
  import branch_jump_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int LANES     = 2,
  parameter int BTB_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [LANES-1:0]      in_valid_i,
  input  logic [LANES*XLEN-1:0] pc_i,
  input  logic [LANES*7-1:0]    opcode_i,
  input  logic [LANES*XLEN-1:0] imm_i,
  input  logic [LANES*XLEN-1:0] rs1_i,
  output logic [LANES-1:0]      out_valid_o,
  output logic [LANES*XLEN-1:0] target_o,
  output logic [LANES-1:0]      branch_o,
  output logic [LANES-1:0]      jump_o,
  output logic [LANES-1:0]      misalign_o,
  output logic [LANES-1:0]      pred_taken_o,
  input  logic                  upd_valid_i,
  input  logic [XLEN-1:0]       upd_pc_i,
  input  logic                  upd_taken_i,
  input  logic [XLEN-1:0]       upd_target_i
);

  logic [LANES-1:0]      btb_taken;
  logic [LANES-1:0]      n_valid, n_branch, n_jump, n_mis, n_pred;
  logic [LANES*XLEN-1:0] n_target;

  bju_btb #(
    .XLEN      (XLEN),
    .LANES     (LANES),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_pc      (pc_i),
    .rd_taken   (btb_taken),
    .upd_valid  (upd_valid_i),
    .upd_pc     (upd_pc_i),
    .upd_taken  (upd_taken_i),
    .upd_target (upd_target_i)
  );

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [XLEN-1:0] pc, imm, rs1, base, sum, tgt;
    logic [6:0]      op;
    logic            is_b, is_jalr, is_j, ctrl;

    assign pc      = pc_i[k*XLEN +: XLEN];
    assign imm     = imm_i[k*XLEN +: XLEN];
    assign rs1     = rs1_i[k*XLEN +: XLEN];
    assign op      = opcode_i[k*7 +: 7];
    assign is_b    = (op == B_TYPE);
    assign is_jalr = (op == JALR_TYPE);
    assign is_j    = (op == J_TYPE) || is_jalr;
    assign ctrl    = in_valid_i[k] && (is_b || is_j);

    assign base = is_jalr ? rs1 : pc;
    assign sum  = base + imm;
    assign tgt  = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;

    assign n_valid[k]                 = ctrl;
    assign n_branch[k]                = ctrl && is_b;
    assign n_jump[k]                  = ctrl && is_j;
    assign n_target[k*XLEN +: XLEN]   = ctrl ? tgt : '0;
    assign n_mis[k]                   = ctrl && tgt[1];
    // A ctrl lane that is not a jump is a branch, so the BTB result applies directly
    assign n_pred[k]                  = ctrl && (is_j || btb_taken[k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o  <= '0;
      target_o     <= '0;
      branch_o     <= '0;
      jump_o       <= '0;
      misalign_o   <= '0;
      pred_taken_o <= '0;
    end else if (flush_i) begin
      out_valid_o  <= '0;
      target_o     <= '0;
      branch_o     <= '0;
      jump_o       <= '0;
      misalign_o   <= '0;
      pred_taken_o <= '0;
    end else if (!stall_i) begin
      out_valid_o  <= n_valid;
      target_o     <= n_target;
      branch_o     <= n_branch;
      jump_o       <= n_jump;
      misalign_o   <= n_mis;
      pred_taken_o <= n_pred;
    end
  end

endmodule

// File: tb/tb_branch_jump_unit.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_branch_jump_unit;
  localparam int XLEN  = 32;
  localparam int LANES = 2;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  stall_i, flush_i;
  logic [LANES-1:0]      in_valid_i;
  logic [LANES*XLEN-1:0] pc_i, imm_i, rs1_i;
  logic [LANES*7-1:0]    opcode_i;
  logic [LANES-1:0]      out_valid_o, branch_o, jump_o, misalign_o, pred_taken_o;
  logic [LANES*XLEN-1:0] target_o;
  logic                  upd_valid_i, upd_taken_i;
  logic [XLEN-1:0]       upd_pc_i, upd_target_i;

  int n_tests = 0;
  int n_fail  = 0;

  branch_jump_unit #(.XLEN(XLEN), .LANES(LANES), .BTB_DEPTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .pc_i         (pc_i),
    .opcode_i     (opcode_i),
    .imm_i        (imm_i),
    .rs1_i        (rs1_i),
    .out_valid_o  (out_valid_o),
    .target_o     (target_o),
    .branch_o     (branch_o),
    .jump_o       (jump_o),
    .misalign_o   (misalign_o),
    .pred_taken_o (pred_taken_o),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_taken_i  (upd_taken_i),
    .upd_target_i (upd_target_i)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: BTB as plain arrays of ints, outputs as expected values
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  int          m_ctr   [16];
  logic [1:0]  e_ov, e_br, e_jp, e_mis, e_pred;
  logic [31:0] e_tgt [LANES];
  bit          e_dc;

  always @(posedge clk or negedge rst_n) begin : model
    logic [6:0]  op;
    logic [31:0] pc, imm, rs1, t;
    int          idx;
    bit          ctrl, hit;
    logic [1:0]  ov, br, jp, mis, pr;
    logic [31:0] tg [LANES];
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 0; end
      e_ov = 0; e_br = 0; e_jp = 0; e_mis = 0; e_pred = 0; e_dc = 0;
      for (int k = 0; k < LANES; k++) e_tgt[k] = 0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        op  = opcode_i[k*7 +: 7];
        pc  = pc_i[k*XLEN +: XLEN];
        imm = imm_i[k*XLEN +: XLEN];
        rs1 = rs1_i[k*XLEN +: XLEN];
        ctrl = in_valid_i[k] && (op == OP_B || op == OP_J || op == OP_JALR);
        if (op == OP_JALR) t = (rs1 + imm) & 32'hFFFF_FFFE;
        else               t = pc + imm;
        idx = int'((pc / 4) % 16);
        hit = m_valid[idx] && (m_tag[idx] == pc / 64);
        ov[k]  = ctrl;
        br[k]  = ctrl && op == OP_B;
        jp[k]  = ctrl && op != OP_B;
        tg[k]  = ctrl ? t : 32'h0;
        mis[k] = ctrl && t[1];
        pr[k]  = ctrl && (op != OP_B || (hit && m_ctr[idx] >= 2));
      end
      if (flush_i) begin
        e_ov = 0; e_dc = 1;
      end else if (!stall_i) begin
        e_ov = ov; e_br = br; e_jp = jp; e_mis = mis; e_pred = pr; e_dc = 0;
        for (int k = 0; k < LANES; k++) e_tgt[k] = tg[k];
      end
      if (upd_valid_i) begin
        idx = int'((upd_pc_i / 4) % 16);
        hit = m_valid[idx] && (m_tag[idx] == upd_pc_i / 64);
        if (hit) m_ctr[idx] = upd_taken_i ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                                          : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
        else if (upd_taken_i) begin
          m_valid[idx] = 1; m_tag[idx] = upd_pc_i / 64; m_ctr[idx] = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        chk("out_valid", 32'(out_valid_o[k]), 32'(e_ov[k]));
        if (!e_dc) begin
          chk("branch",   32'(branch_o[k]),     32'(e_br[k]));
          chk("jump",     32'(jump_o[k]),       32'(e_jp[k]));
          chk("misalign", 32'(misalign_o[k]),   32'(e_mis[k]));
          chk("pred",     32'(pred_taken_o[k]), 32'(e_pred[k]));
          chk("target",   target_o[k*XLEN +: XLEN], e_tgt[k]);
        end
      end
    end
  end

  task automatic set_lane(int k, bit v, logic [6:0] op, logic [31:0] pc, logic [31:0] imm,
                          logic [31:0] rs1);
    in_valid_i[k]          = v;
    opcode_i[k*7 +: 7]     = op;
    pc_i[k*XLEN +: XLEN]   = pc;
    imm_i[k*XLEN +: XLEN]  = imm;
    rs1_i[k*XLEN +: XLEN]  = rs1;
  endtask

  task automatic upd(bit v, logic [31:0] pc, bit taken, logic [31:0] tgt);
    upd_valid_i = v; upd_pc_i = pc; upd_taken_i = taken; upd_target_i = tgt;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_pc();
    if ($urandom_range(0, 9) == 0) return $urandom & 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    rst_n = 0; stall_i = 0; flush_i = 0;
    in_valid_i = 0; pc_i = 0; imm_i = 0; rs1_i = 0; opcode_i = 0;
    upd(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // 1: asynchronous reset mid-stream
    set_lane(0, 1, OP_B, 32'h100, 32'h10, 0);
    set_lane(1, 1, OP_J, 32'h200, 32'h20, 0);
    step();
    chk("t1 ov before reset", 32'(out_valid_o), 32'h3);
    #2 rst_n = 0;
    #1;
    chk("t1 ov async", 32'(out_valid_o), 32'h0);
    chk("t1 tgt0 async", target_o[31:0], 32'h0);
    chk("t1 tgt1 async", target_o[63:32], 32'h0);
    chk("t1 pred async", 32'(pred_taken_o), 32'h0);
    chk("t1 jump async", 32'(jump_o), 32'h0);
    @(negedge clk);
    rst_n = 1;
    set_lane(0, 1, OP_B, 32'h100, 32'h10, 0);
    set_lane(1, 0, OP_ALU, 0, 0, 0);
    step();
    chk("t1 ov after", 32'(out_valid_o), 32'h1);
    chk("t1 pred after", 32'(pred_taken_o[0]), 32'h0);

    // 2: target arithmetic
    set_lane(0, 1, OP_B, 32'h1000, 32'hFFFF_FFF8, 0);
    set_lane(1, 1, OP_JALR, 32'h40, 32'h4, 32'h2003);
    step();
    chk("t2 tgt0", target_o[31:0], 32'h0000_0FF8);
    chk("t2 tgt1", target_o[63:32], 32'h0000_2006);
    chk("t2 mis", 32'(misalign_o), 32'h2);
    chk("t2 jump", 32'(jump_o), 32'h2);
    chk("t2 branch", 32'(branch_o), 32'h1);

    // 3: training and saturation
    in_valid_i = 0;
    upd(1, 32'h40, 1, 32'h80);
    repeat (3) step();
    upd(0, 0, 0, 0);
    set_lane(0, 1, OP_B, 32'h40, 32'h8, 0);
    step();
    chk("t3 pred strong", 32'(pred_taken_o[0]), 32'h1);
    in_valid_i = 0;
    upd(1, 32'h40, 0, 0);
    repeat (3) step();
    upd(0, 0, 0, 0);
    set_lane(0, 1, OP_B, 32'h40, 32'h8, 0);
    step();
    chk("t3 pred weak-nt", 32'(pred_taken_o[0]), 32'h0);
    in_valid_i = 0;
    upd(1, 32'h40, 0, 0);
    step();
    upd(1, 32'h40, 1, 32'h80);
    step();
    upd(0, 0, 0, 0);
    set_lane(0, 1, OP_B, 32'h40, 32'h8, 0);
    step();
    chk("t3 no wrap", 32'(pred_taken_o[0]), 32'h0);

    // 4: aliasing index, lookup sees pre-update contents
    in_valid_i = 0;
    upd(1, 32'h40, 1, 32'h80);
    step();
    set_lane(0, 1, OP_B, 32'h80, 32'h4, 0);
    upd(1, 32'h80, 1, 32'h300);
    step();
    chk("t4 alias miss", 32'(pred_taken_o[0]), 32'h0);
    upd(0, 0, 0, 0);
    set_lane(0, 1, OP_B, 32'h80, 32'h4, 0);
    set_lane(1, 1, OP_B, 32'h40, 32'h4, 0);
    step();
    chk("t4 replaced new", 32'(pred_taken_o[0]), 32'h1);
    chk("t4 replaced old", 32'(pred_taken_o[1]), 32'h0);

    // 5: stall, flush, training during stall
    set_lane(0, 1, OP_B, 32'h80, 32'h40, 0);
    set_lane(1, 1, OP_J, 32'h500, 32'h10, 0);
    step();
    stall_i = 1;
    set_lane(0, 1, OP_JALR, 32'h0, 32'h1, 32'h777);
    set_lane(1, 1, OP_B, 32'h200, 32'h8, 0);
    upd(1, 32'h200, 1, 32'h10);
    for (int i = 0; i < 3; i++) begin
      step();
      upd(0, 0, 0, 0);
      chk("t5 stall tgt0", target_o[31:0], 32'h0000_00C0);
      chk("t5 stall tgt1", target_o[63:32], 32'h0000_0510);
      chk("t5 stall pred", 32'(pred_taken_o), 32'h3);
    end
    flush_i = 1;
    step();
    chk("t5 flush+stall ov", 32'(out_valid_o), 32'h0);
    flush_i = 0; stall_i = 0;
    set_lane(0, 1, OP_B, 32'h200, 32'h8, 0);
    in_valid_i[1] = 0;
    step();
    chk("t5 trained in stall", 32'(pred_taken_o[0]), 32'h1);

    // 6: wraparound and non-control opcode
    set_lane(0, 1, OP_J, 32'hFFFF_FFFC, 32'h8, 0);
    set_lane(1, 1, OP_ALU, 32'h300, 32'h4, 0);
    step();
    chk("t6 wrap tgt", target_o[31:0], 32'h0000_0004);
    chk("t6 ov", 32'(out_valid_o), 32'h1);
    chk("t6 nonctrl tgt", target_o[63:32], 32'h0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < LANES; k++) begin
        logic [6:0] op;
        case ($urandom_range(0, 5))
          0, 1:    op = OP_B;
          2:       op = OP_J;
          3:       op = OP_JALR;
          4:       op = OP_ALU;
          default: op = OP_LD;
        endcase
        set_lane(k, $urandom_range(0, 3) != 0, op, rnd_pc(),
                 32'($signed($urandom_range(0, 511)) - 256), $urandom);
      end
      stall_i = ($urandom_range(0, 7) == 0);
      flush_i = ($urandom_range(0, 15) == 0);
      upd($urandom_range(0, 1) == 1, rnd_pc(), $urandom_range(0, 2) != 0, $urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
